dispatch_ctrl: RTL and testbench
================================

Name: dispatch_ctrl

Overview:
- Sits between instruction fetch and the out-of-order back end.
- Buffers fetched instructions in a small FIFO and drives the head instruction into the combinational decoder.
- Uses the decoded fields to dispatch one instruction per cycle: every instruction to the ROB, plus loads/stores to the LSB and everything else to the RS.
- Provides fetch back-pressure, stalls on full back-end structures, and flushes on rollback.

Parameters:
- DEPTH, 4, instruction FIFO entries (power of two, >=2)
- INS_LEN, 32, instruction width
- ADDR_LEN, 32, pc width
- OPENUM_LEN, 6, decoded opcode-enum width
- REG_LEN, 5, register index width
- DATA_LEN, 32, immediate width
- ROB_TAG_LEN, 4, ROB entry tag width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low = freeze
- rollback  in  1  flush request from ROB
- fetch_valid  in  1  fetch offers instruction
- fetch_inst  in  INS_LEN  offered instruction
- fetch_pc  in  ADDR_LEN  pc of offered instruction
- fetch_rdy  out  1  FIFO can accept (comb: count<DEPTH && !rollback)
- dec_inst  out  INS_LEN  FIFO head to decoder (comb); ZERO_WORD when empty
- dec_openum  in  OPENUM_LEN  decoder result
- dec_rd  in  REG_LEN  decoder result
- dec_rs1  in  REG_LEN  decoder result
- dec_rs2  in  REG_LEN  decoder result
- dec_imm  in  DATA_LEN  decoder result
- rob_full  in  1  ROB cannot accept
- rob_free_tag  in  ROB_TAG_LEN  tag of next ROB slot
- rs_full  in  1  RS cannot accept
- lsb_full  in  1  LSB cannot accept
- rob_en  out  1  one-cycle dispatch pulse to ROB
- rs_en  out  1  one-cycle dispatch pulse to RS
- lsb_en  out  1  one-cycle dispatch pulse to LSB
- out_openum  out  OPENUM_LEN  registered dispatch field
- out_rd  out  REG_LEN  registered dispatch field
- out_rs1  out  REG_LEN  registered dispatch field
- out_rs2  out  REG_LEN  registered dispatch field
- out_imm  out  DATA_LEN  registered dispatch field
- out_pc  out  ADDR_LEN  registered dispatch field
- out_rob_tag  out  ROB_TAG_LEN  registered dispatch field

Behaviour:
- Reset (rst=1 at posedge): head, tail and count = 0; all *_en = 0; all out_* = 0. Takes priority over rdy and rollback.
- rdy=0: FIFO state and out_* hold; *_en forced 0 at next edge.
- FIFO: circular, head/tail wrap modulo DEPTH, count 0..DEPTH.
  - Push when fetch_valid && fetch_rdy && rdy.
  - When full, fetch_rdy=0 even if a pop occurs in the same cycle; no bypass from fetch to dispatch.
- Class is taken from head opcode bits [6:0]:
  - MEM = OPCODE_L (0000011) or OPCODE_S (0100011).
  - Otherwise ALU.
  - NOP = dec_openum == OPENUM_NOP.
- Dispatch fires when count>0 && rdy && !rollback && !rob_full && (MEM ? !lsb_full : !rs_full).
  - Pop head.
  - Next cycle: rob_en=1, lsb_en=MEM, rs_en=!MEM; out_* = decoder fields, head pc, rob_free_tag.
- NOP head: popped when count>0 && rdy && !rollback, with no *_en asserted and no dependence on the full flags.
- No fire: *_en = 0 next cycle; out_* hold previous values.
- Latency: instruction pushed at edge N can dispatch at edge N+1 at the earliest; *_en visible after edge N+1. Throughput 1 per cycle.
- Rollback (rdy=1): at next edge head=tail=count=0 and all *_en=0. No push or pop that cycle. A pulse already registered in the rollback cycle is still visible that cycle; the ROB discards it.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Stall on a full target holds the head; a younger instruction never bypasses it (in-order dispatch).

Test Plan:
- Reset, then push ADDI x1,x0,5 (0x00500093, pc 0x0) -> two edges later rob_en=rs_en=1, lsb_en=0, out_rd=1, out_imm=5, out_pc=0, out_rob_tag=rob_free_tag.
- Push LW x2,0(x1) (0x0000A103) then SW x2,4(x1) (0x0020A223) -> consecutive pulses with lsb_en=1 and rs_en=0; SW out_imm=4.
- lsb_full=1 with LW at head and ADDI behind -> no *_en for 3 cycles; lsb_full drop -> LW dispatched first, ADDI next cycle.
- rob_full=1 while fetch_valid is held -> count reaches 4, fetch_rdy=0; release -> four consecutive dispatches, fetch_rdy re-asserts after first pop edge.
- Three queued instructions, assert rollback one cycle with fetch_valid=1 -> count=0, no push, *_en=0 next cycle, dec_inst=0.
- Push 0x00000000 (NOP openum) -> popped, no *_en pulse; following ADDI dispatches normally.

Source files
------------

// File: rtl/dispatch_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dispatch_ctrl_if                                           |
// | Brief    : Fetch, decoder and back-end signals of the dispatch stage  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
interface dispatch_ctrl_if #(
    parameter int INS_LEN     = 32,
    parameter int ADDR_LEN    = 32,
    parameter int OPENUM_LEN  = 6,
    parameter int REG_LEN     = 5,
    parameter int DATA_LEN    = 32,
    parameter int ROB_TAG_LEN = 4
);
    logic                   rdy;
    logic                   rollback;
    logic                   fetch_valid;
    logic [INS_LEN-1:0]     fetch_inst;
    logic [ADDR_LEN-1:0]    fetch_pc;
    logic                   fetch_rdy;
    logic [INS_LEN-1:0]     dec_inst;
    logic [OPENUM_LEN-1:0]  dec_openum;
    logic [REG_LEN-1:0]     dec_rd;
    logic [REG_LEN-1:0]     dec_rs1;
    logic [REG_LEN-1:0]     dec_rs2;
    logic [DATA_LEN-1:0]    dec_imm;
    logic                   rob_full;
    logic [ROB_TAG_LEN-1:0] rob_free_tag;
    logic                   rs_full;
    logic                   lsb_full;
    logic                   rob_en;
    logic                   rs_en;
    logic                   lsb_en;
    logic [OPENUM_LEN-1:0]  out_openum;
    logic [REG_LEN-1:0]     out_rd;
    logic [REG_LEN-1:0]     out_rs1;
    logic [REG_LEN-1:0]     out_rs2;
    logic [DATA_LEN-1:0]    out_imm;
    logic [ADDR_LEN-1:0]    out_pc;
    logic [ROB_TAG_LEN-1:0] out_rob_tag;

    // Dispatch controller side.
    modport master (
        input  rdy, rollback, fetch_valid, fetch_inst, fetch_pc,
        input  dec_openum, dec_rd, dec_rs1, dec_rs2, dec_imm,
        input  rob_full, rob_free_tag, rs_full, lsb_full,
        output fetch_rdy, dec_inst, rob_en, rs_en, lsb_en,
        output out_openum, out_rd, out_rs1, out_rs2, out_imm, out_pc, out_rob_tag
    );

    // Surrounding pipeline side.
    modport slave (
        output rdy, rollback, fetch_valid, fetch_inst, fetch_pc,
        output dec_openum, dec_rd, dec_rs1, dec_rs2, dec_imm,
        output rob_full, rob_free_tag, rs_full, lsb_full,
        input  fetch_rdy, dec_inst, rob_en, rs_en, lsb_en,
        input  out_openum, out_rd, out_rs1, out_rs2, out_imm, out_pc, out_rob_tag
    );
endinterface
`default_nettype wire

// File: rtl/dispatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dispatch_ctrl                                              |
// | Brief    : Instruction FIFO and in-order dispatch to ROB / RS / LSB   |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module dispatch_ctrl #(
    parameter int DEPTH       = 4,
    parameter int INS_LEN     = 32,
    parameter int ADDR_LEN    = 32,
    parameter int OPENUM_LEN  = 6,
    parameter int REG_LEN     = 5,
    parameter int DATA_LEN    = 32,
    parameter int ROB_TAG_LEN = 4,
    parameter int OPENUM_NOP  = 0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    dispatch_ctrl_if.master   bus
);
    localparam int                c_PTR_W    = $clog2(DEPTH);
    localparam int                c_CNT_W    = c_PTR_W + 1;
    localparam logic [6:0]        c_OPCODE_L = 7'b0000011;
    localparam logic [6:0]        c_OPCODE_S = 7'b0100011;
    localparam logic [INS_LEN-1:0] c_ZERO_WORD = '0;

    logic [INS_LEN-1:0]  r_inst_mem [DEPTH];
    logic [ADDR_LEN-1:0] r_pc_mem   [DEPTH];
    logic [c_PTR_W-1:0]  r_head;
    logic [c_PTR_W-1:0]  r_tail;
    logic [c_CNT_W-1:0]  r_count;

    logic                r_rob_en;
    logic                r_rs_en;
    logic                r_lsb_en;
    logic [OPENUM_LEN-1:0]  r_openum;
    logic [REG_LEN-1:0]     r_rd;
    logic [REG_LEN-1:0]     r_rs1;
    logic [REG_LEN-1:0]     r_rs2;
    logic [DATA_LEN-1:0]    r_imm;
    logic [ADDR_LEN-1:0]    r_pc;
    logic [ROB_TAG_LEN-1:0] r_rob_tag;

    logic               w_empty;
    logic               w_full;
    logic [INS_LEN-1:0] w_head_inst;
    logic               w_is_mem;
    logic               w_is_nop;
    logic               w_go;
    logic               w_fire;
    logic               w_pop;
    logic               w_push;
    logic               w_fetch_rdy;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_CNT_W'(DEPTH));
    assign w_head_inst = r_inst_mem[r_head];
    assign w_is_mem    = (w_head_inst[6:0] == c_OPCODE_L) || (w_head_inst[6:0] == c_OPCODE_S);
    assign w_is_nop    = (bus.dec_openum == OPENUM_LEN'(OPENUM_NOP));

    // A NOP head only needs a live pipeline to drain; real work also needs its target.
    assign w_go        = !w_empty && bus.rdy && !bus.rollback;
    assign w_fire      = w_go && !w_is_nop && !bus.rob_full &&
                         (w_is_mem ? !bus.lsb_full : !bus.rs_full);
    assign w_pop       = w_go && (w_is_nop || w_fire);
    assign w_fetch_rdy = !w_full && !bus.rollback;
    assign w_push      = bus.fetch_valid && w_fetch_rdy && bus.rdy;

    assign bus.fetch_rdy   = w_fetch_rdy;
    assign bus.dec_inst    = w_empty ? c_ZERO_WORD : w_head_inst;
    assign bus.rob_en      = r_rob_en;
    assign bus.rs_en       = r_rs_en;
    assign bus.lsb_en      = r_lsb_en;
    assign bus.out_openum  = r_openum;
    assign bus.out_rd      = r_rd;
    assign bus.out_rs1     = r_rs1;
    assign bus.out_rs2     = r_rs2;
    assign bus.out_imm     = r_imm;
    assign bus.out_pc      = r_pc;
    assign bus.out_rob_tag = r_rob_tag;

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_inst_mem[r_tail] <= bus.fetch_inst;
            r_pc_mem[r_tail]   <= bus.fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_rob_en  <= 1'b0;
            r_rs_en   <= 1'b0;
            r_lsb_en  <= 1'b0;
            r_openum  <= '0;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_imm     <= '0;
            r_pc      <= '0;
            r_rob_tag <= '0;
        end else if (!bus.rdy) begin
            r_rob_en <= 1'b0;
            r_rs_en  <= 1'b0;
            r_lsb_en <= 1'b0;
        end else if (bus.rollback) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_rob_en <= 1'b0;
            r_rs_en  <= 1'b0;
            r_lsb_en <= 1'b0;
        end else begin
            if (w_pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            if (w_push) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            r_count  <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
            r_rob_en <= w_fire;
            r_rs_en  <= w_fire && !w_is_mem;
            r_lsb_en <= w_fire && w_is_mem;
            if (w_fire) begin
                r_openum  <= bus.dec_openum;
                r_rd      <= bus.dec_rd;
                r_rs1     <= bus.dec_rs1;
                r_rs2     <= bus.dec_rs2;
                r_imm     <= bus.dec_imm;
                r_pc      <= r_pc_mem[r_head];
                r_rob_tag <= bus.rob_free_tag;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dispatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_dispatch_ctrl                                           |
// | Brief    : Directed and random checks of dispatch_ctrl vs queue model |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dispatch_ctrl;
    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } dec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    dispatch_ctrl_if bus ();

    dispatch_ctrl #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference decoder: openum 0 only for the all-zero word.
    function automatic dec_t decode(input logic [31:0] i);
        dec_t d;
        d.op  = (i == 32'h0) ? 6'd0 : 6'(i[6:2]) + 6'd1;
        d.rd  = i[11:7];
        d.rs1 = i[19:15];
        d.rs2 = i[24:20];
        d.imm = (i[6:0] == 7'b0100011) ? {{20{i[31]}}, i[31:25], i[11:7]}
                                       : {{20{i[31]}}, i[31:20]};
        return d;
    endfunction

    dec_t w_dd;
    assign w_dd           = decode(bus.dec_inst);
    assign bus.dec_openum = w_dd.op;
    assign bus.dec_rd     = w_dd.rd;
    assign bus.dec_rs1    = w_dd.rs1;
    assign bus.dec_rs2    = w_dd.rs2;
    assign bus.dec_imm    = w_dd.imm;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t        q[$];
    logic        e_rob, e_rs, e_lsb;
    dec_t        e_dec;
    logic [31:0] e_pc;
    logic [3:0]  e_tag;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check combinational outputs, advance model, check registered outputs.
    task automatic step(input bit a_rst, input bit a_rdy, input bit a_rb, input bit a_fv,
                        input logic [31:0] a_inst, input logic [31:0] a_pc,
                        input bit a_robf, input bit a_rsf, input bit a_lsbf, input logic [3:0] a_tag);
        bit   fire, pop, push, mem;
        dec_t hd;
        rst              = a_rst;
        bus.rdy          = a_rdy;
        bus.rollback     = a_rb;
        bus.fetch_valid  = a_fv;
        bus.fetch_inst   = a_inst;
        bus.fetch_pc     = a_pc;
        bus.rob_full     = a_robf;
        bus.rs_full      = a_rsf;
        bus.lsb_full     = a_lsbf;
        bus.rob_free_tag = a_tag;
        #1;
        if (!a_rst) begin
            check("fetch_rdy", 64'(bus.fetch_rdy), 64'((q.size() < 4) && !a_rb));
            check("dec_inst", 64'(bus.dec_inst), (q.size() > 0) ? 64'(q[0].inst) : 64'd0);
        end
        if (a_rst) begin
            q.delete();
            {e_rob, e_rs, e_lsb} = 3'b000;
            e_dec = '0;
            e_pc  = '0;
            e_tag = '0;
        end else if (!a_rdy || a_rb) begin
            {e_rob, e_rs, e_lsb} = 3'b000;
            if (a_rdy) q.delete();
        end else begin
            fire = 1'b0;
            pop  = 1'b0;
            mem  = 1'b0;
            hd   = '0;
            if (q.size() > 0) begin
                hd   = decode(q[0].inst);
                mem  = (q[0].inst[6:0] == 7'b0000011) || (q[0].inst[6:0] == 7'b0100011);
                fire = (hd.op != 0) && !a_robf && (mem ? !a_lsbf : !a_rsf);
                pop  = (hd.op == 0) || fire;
            end
            push  = a_fv && (q.size() < 4);
            e_rob = fire;
            e_rs  = fire && !mem;
            e_lsb = fire && mem;
            if (fire) begin
                e_dec = hd;
                e_pc  = q[0].pc;
                e_tag = a_tag;
            end
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{inst: a_inst, pc: a_pc});
        end
        @(posedge clk);
        #1;
        check("rob_en", 64'(bus.rob_en), 64'(e_rob));
        check("rs_en", 64'(bus.rs_en), 64'(e_rs));
        check("lsb_en", 64'(bus.lsb_en), 64'(e_lsb));
        check("out_openum", 64'(bus.out_openum), 64'(e_dec.op));
        check("out_rd", 64'(bus.out_rd), 64'(e_dec.rd));
        check("out_rs1", 64'(bus.out_rs1), 64'(e_dec.rs1));
        check("out_rs2", 64'(bus.out_rs2), 64'(e_dec.rs2));
        check("out_imm", 64'(bus.out_imm), 64'(e_dec.imm));
        check("out_pc", 64'(bus.out_pc), 64'(e_pc));
        check("out_rob_tag", 64'(bus.out_rob_tag), 64'(e_tag));
    endtask

    task automatic push1(input logic [31:0] inst, input logic [31:0] pc,
                         input bit robf, input bit rsf, input bit lsbf);
        step(0, 1, 0, 1, inst, pc, robf, rsf, lsbf, 4'($urandom));
    endtask

    task automatic idle(input bit robf, input bit rsf, input bit lsbf);
        step(0, 1, 0, 0, 32'h0, 32'h0, robf, rsf, lsbf, 4'($urandom));
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0:       return 32'h0;
            1:       return {r[31:7], 7'b0000011};
            2:       return {r[31:7], 7'b0100011};
            3:       return {r[31:7], 7'b0010011};
            default: return {r[31:7], 7'b0110011};
        endcase
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        #1;
        step(1, 1, 0, 1, 32'h00500093, 32'h0, 0, 0, 0, 4'h0);
        step(1, 1, 1, 1, 32'h00500093, 32'h0, 0, 0, 0, 4'h0);

        // ADDI x1,x0,5 reaches the RS two edges after being offered.
        step(0, 1, 0, 1, 32'h00500093, 32'h0, 0, 0, 0, 4'h0);
        step(0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0, 4'h9);
        check("addi_imm", 64'(bus.out_imm), 64'd5);
        check("addi_tag", 64'(bus.out_rob_tag), 64'h9);

        // LW then SW: back-to-back LSB pulses.
        push1(32'h0000A103, 32'h4, 0, 0, 0);
        push1(32'h0020A223, 32'h8, 0, 0, 0);
        idle(0, 0, 0);
        check("sw_imm", 64'(bus.out_imm), 64'd4);
        check("sw_lsb", 64'(bus.lsb_en), 64'd1);
        idle(0, 0, 0);

        // LSB full holds LW at head; ADDI behind it must wait.
        push1(32'h0000A103, 32'h10, 0, 0, 1);
        push1(32'h00500093, 32'h14, 0, 0, 1);
        repeat (3) idle(0, 0, 1);
        idle(0, 0, 0);
        check("lw_first_pc", 64'(bus.out_pc), 64'h10);
        idle(0, 0, 0);
        check("addi_next_pc", 64'(bus.out_pc), 64'h14);

        // ROB full fills the FIFO, then four consecutive dispatches.
        for (int i = 0; i < 5; i++) push1(32'h00100113 + 32'(i << 20), 32'(32'h100 + 4 * i), 1, 0, 0);
        repeat (5) idle(0, 0, 0);

        // Rollback with three queued and fetch still offering.
        for (int i = 0; i < 3; i++) push1(32'h00500093, 32'(32'h200 + 4 * i), 1, 0, 0);
        step(0, 1, 1, 1, 32'h00500093, 32'h300, 1, 0, 0, 4'h1);
        idle(0, 0, 0);
        check("rb_empty", 64'(bus.dec_inst), 64'd0);

        // NOP is drained silently; following ADDI dispatches.
        push1(32'h0, 32'h400, 0, 0, 0);
        push1(32'h00500093, 32'h404, 0, 0, 0);
        idle(0, 0, 0);
        idle(0, 0, 0);
        check("after_nop_pc", 64'(bus.out_pc), 64'h404);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 7),
                 rand_inst(), $urandom,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0),
                 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
